// File: rtl/ram_seq_ctrl.sv
// Sequencer for the 256x16 sync RAM: single/burst writes (fill) and burst reads over valid/ready.
// First read word returns RD_LAT+1 cycles after acceptance; req_ready only in IDLE, read data cannot be stalled.
module ram_seq_ctrl #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [7:0]  req_addr,
   input  logic [3:0]  req_len,
   input  logic [15:0] req_wdata,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   output logic        rd_last,
   output logic        done,
   output logic        busy,
   output logic [7:0]  ram_addr,
   output logic [15:0] ram_din,
   output logic        ram_we,
   input  logic [15:0] ram_dout
);
   typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;

   typedef struct packed {
      logic [7:0]  addr;
      logic [3:0]  cnt;
      logic [15:0] wdata;
   } req_t;

   state_t          state, state_nxt;
   req_t            cur, cur_nxt;
   logic [RD_LAT:0] tag_vld, tag_last;
   logic            issue, last_word, wr_done;

   assign last_word = (cur.cnt == 4'd0);
   assign issue     = (state == ISSUE);

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt     = req_write ? WRITE : ISSUE;
               cur_nxt.addr  = req_addr;
               cur_nxt.cnt   = req_len;
               cur_nxt.wdata = req_wdata;
            end
         end
         WRITE, ISSUE: begin
            cur_nxt.addr = cur.addr + 8'd1;
            cur_nxt.cnt  = cur.cnt - 4'd1;
            if (last_word) state_nxt = (state == WRITE) ? IDLE : DRAIN;
         end
         DRAIN: begin
            // the last tag always enters the pipe as ISSUE exits, so it is still in flight here
            if (tag_vld[RD_LAT] && tag_last[RD_LAT]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cur      <= '0;
         tag_vld  <= '0;
         tag_last <= '0;
         rd_data  <= '0;
         wr_done  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur      <= cur_nxt;
         tag_vld  <= {tag_vld[RD_LAT-1:0], issue};
         tag_last <= {tag_last[RD_LAT-1:0], issue && last_word};
         if (tag_vld[RD_LAT-1]) rd_data <= ram_dout;
         wr_done  <= (state == WRITE) && last_word;
      end
   end

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign ram_we    = (state == WRITE);
   assign ram_addr  = cur.addr;
   assign ram_din   = cur.wdata;
   assign rd_valid  = tag_vld[RD_LAT];
   assign rd_last   = tag_vld[RD_LAT] && tag_last[RD_LAT];
   assign done      = wr_done || (rd_valid && rd_last);

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: three instances (RD_LAT 1..3), each with its own RAM model, exercised in turn.
module tb_ram_seq_ctrl;
   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, preload;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [3:0]  req_len;
   logic [15:0] req_wdata;
   logic        req_valid [N];
   logic        req_ready [N];
   logic        rd_valid  [N];
   logic [15:0] rd_data   [N];
   logic        rd_last   [N];
   logic        done      [N];
   logic        busy      [N];
   logic [7:0]  ram_addr  [N];
   logic [15:0] ram_din   [N];
   logic        ram_we    [N];
   logic [15:0] ram_dout  [N];

   int checks = 0;
   int errors = 0;
   logic [15:0] ref_mem [N][256];

   function automatic logic [15:0] init_word(input int a);
      return 16'(a * 37) ^ 16'hA5C3;
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_inst
      logic [15:0] mem [256];
      logic [15:0] rq  [g+1];
      always @(posedge clk) begin
         if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         end else if (ram_we[g]) begin
            mem[ram_addr[g]] <= ram_din[g];
         end
         rq[0] <= mem[ram_addr[g]];
         for (int j = 1; j <= g; j++) rq[j] <= rq[j-1];
      end
      assign ram_dout[g] = rq[g];

      ram_seq_ctrl #(.RD_LAT(g + 1)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write),
         .req_addr  (req_addr),
         .req_len   (req_len),
         .req_wdata (req_wdata),
         .rd_valid  (rd_valid[g]),
         .rd_data   (rd_data[g]),
         .rd_last   (rd_last[g]),
         .done      (done[g]),
         .busy      (busy[g]),
         .ram_addr  (ram_addr[g]),
         .ram_din   (ram_din[g]),
         .ram_we    (ram_we[g]),
         .ram_dout  (ram_dout[g])
      );
   end

   task automatic wait_ready(input int k);
      int n = 0;
      while (req_ready[k] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready[k] !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready lat%0d: req_ready=%b required 1 within 100 cycles", k + 1, req_ready[k]);
      end
   endtask

   // Drives one request and checks every cycle until the controller is idle again.
   task automatic run_req(input int k, input bit w, input logic [7:0] a, input logic [3:0] l,
                          input logic [15:0] d);
      int lat = k + 1;
      int last_c;
      logic [15:0] exp_word [16];
      wait_ready(k);
      for (int i = 0; i <= int'(l); i++) exp_word[i] = ref_mem[k][8'(int'(a) + i)];
      req_valid[k] = 1'b1;
      req_write = w; req_addr = a; req_len = l; req_wdata = d;
      @(negedge clk);
      req_valid[k] = 1'b0;
      req_write = 1'($urandom); req_addr = 8'($urandom); req_len = 4'($urandom); req_wdata = 16'($urandom);
      last_c = w ? int'(l) + 1 : lat + 2 + int'(l);
      for (int c = 0; c <= last_c; c++) begin
         logic [5:0] got, exp;
         bit e_we, e_vld, e_last, e_done, e_busy;
         e_busy = (c < last_c);
         e_we   = w && (c <= int'(l));
         e_vld  = !w && (c >= lat + 1) && (c <= lat + 1 + int'(l));
         e_last = e_vld && (c == lat + 1 + int'(l));
         e_done = (c == (w ? int'(l) + 1 : lat + 1 + int'(l)));
         got = {ram_we[k], rd_valid[k], rd_valid[k] & rd_last[k], done[k], busy[k], req_ready[k]};
         exp = {e_we, e_vld, e_last, e_done, e_busy, !e_busy};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL ctl lat%0d op%0d a=%h l=%0d c=%0d: we,vld,last,done,busy,rdy=%b required %b",
                     lat, w, a, l, c, got, exp);
         end
         if (c <= int'(l)) begin
            checks++;
            if (ram_addr[k] !== 8'(int'(a) + c)) begin
               errors++;
               $display("FAIL addr lat%0d c=%0d: ram_addr=%h required %h", lat, c, ram_addr[k], 8'(int'(a) + c));
            end
         end
         if (e_we) begin
            checks++;
            if (ram_din[k] !== d) begin
               errors++;
               $display("FAIL din lat%0d c=%0d: ram_din=%h required %h", lat, c, ram_din[k], d);
            end
         end
         if (e_vld) begin
            checks++;
            if (rd_data[k] !== exp_word[c - lat - 1]) begin
               errors++;
               $display("FAIL rdata lat%0d a=%h word %0d: rd_data=%h required %h",
                        lat, a, c - lat - 1, rd_data[k], exp_word[c - lat - 1]);
            end
         end
         if (c < last_c) @(negedge clk);
      end
      if (w) for (int i = 0; i <= int'(l); i++) ref_mem[k][8'(int'(a) + i)] = d;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      preload = 1'b1;
      for (int k = 0; k < N; k++)
         for (int a = 0; a < 256; a++) ref_mem[k][a] = init_word(a);
      repeat (3) @(negedge clk);
      preload = 1'b0;
      for (int k = 0; k < N; k++) begin
         logic [47:0] got;
         got = {req_ready[k], busy[k], ram_we[k], ram_addr[k], ram_din[k], rd_valid[k], rd_data[k],
                rd_last[k], done[k]};
         checks++;
         if (got !== {1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset lat%0d: outputs=%h required %h", k + 1, got,
                     {1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single(input int k);
      run_req(k, 1'b1, 8'h10, 4'd0, 16'hBEEF);
      run_req(k, 1'b0, 8'h10, 4'd0, 16'h0000);
   endtask

   task automatic test_fill_wrap(input int k);
      run_req(k, 1'b1, 8'hFE, 4'd3, 16'h1234);
      run_req(k, 1'b0, 8'hFE, 4'd3, 16'h0000);
   endtask

   task automatic test_max_burst(input int k);
      for (int i = 0; i < 16; i++) run_req(k, 1'b1, 8'(8'h40 + i), 4'd0, 16'(16'h0040 + i));
      run_req(k, 1'b0, 8'h40, 4'd15, 16'h0000);
   endtask

   task automatic test_busy(input int k);
      int lat = k + 1;
      int ready_c = -1;
      int we_c = -1;
      int nrd = 0;
      int nwe = 0;
      int ndone = 0;
      logic [15:0] wd;
      logic [15:0] exp_rd [8];
      wd = 16'($urandom);
      wait_ready(k);
      for (int i = 0; i < 8; i++) exp_rd[i] = ref_mem[k][8'h40 + i];
      req_valid[k] = 1'b1;
      req_write = 1'b0; req_addr = 8'h40; req_len = 4'd7;
      @(negedge clk);
      req_write = 1'b1; req_addr = 8'h20; req_len = 4'd0; req_wdata = wd;
      for (int c = 0; c < lat + 14; c++) begin
         if (rd_valid[k]) begin
            checks++;
            if (nrd >= 8) begin
               errors++;
               $display("FAIL busy_rd lat%0d: extra rd_valid at c=%0d, required 8 words only", lat, c);
            end else if (rd_data[k] !== exp_rd[nrd]) begin
               errors++;
               $display("FAIL busy_rd lat%0d word %0d: rd_data=%h required %h", lat, nrd, rd_data[k], exp_rd[nrd]);
            end
            nrd++;
         end
         if (ram_we[k]) begin
            nwe++;
            we_c = c;
            checks++;
            if (ram_addr[k] !== 8'h20 || ram_din[k] !== wd) begin
               errors++;
               $display("FAIL busy_wr lat%0d: addr/din=%h/%h required 20/%h", lat, ram_addr[k], ram_din[k], wd);
            end
         end
         if (done[k]) ndone++;
         if (req_ready[k] && ready_c < 0) ready_c = c;
         if (ready_c >= 0 && c > ready_c) req_valid[k] = 1'b0;
         @(negedge clk);
      end
      req_valid[k] = 1'b0;
      ref_mem[k][8'h20] = wd;
      checks++;
      if (ready_c != lat + 9) begin
         errors++;
         $display("FAIL busy_ready lat%0d: first ready at c=%0d required %0d", lat, ready_c, lat + 9);
      end
      checks++;
      if (nwe != 1 || we_c != lat + 10) begin
         errors++;
         $display("FAIL busy_accept lat%0d: %0d write cycles, last at c=%0d, required 1 at %0d", lat, nwe, we_c, lat + 10);
      end
      checks++;
      if (nrd != 8) begin
         errors++;
         $display("FAIL busy_count lat%0d: %0d words required 8", lat, nrd);
      end
      checks++;
      if (ndone != 2) begin
         errors++;
         $display("FAIL busy_done lat%0d: %0d done pulses required 2", lat, ndone);
      end
   endtask

   task automatic test_reset_mid(input int k);
      int nbad = 0;
      logic [15:0] wd;
      wd = 16'(16'hC0DE + k);
      wait_ready(k);
      req_valid[k] = 1'b1;
      req_write = 1'b1; req_addr = 8'h80; req_len = 4'd5; req_wdata = wd;
      @(negedge clk);
      req_valid[k] = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({ram_we[k], busy[k], done[k], req_ready[k]} !== 4'b0001) begin
         errors++;
         $display("FAIL rst_mid lat%0d: we,busy,done,rdy=%b required 0001", k + 1,
                  {ram_we[k], busy[k], done[k], req_ready[k]});
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ram_we[k] !== 1'b0 || done[k] !== 1'b0) nbad++;
      end
      checks++;
      if (nbad != 0) begin
         errors++;
         $display("FAIL rst_mid_quiet lat%0d: %0d cycles with we/done after reset, required 0", k + 1, nbad);
      end
      ref_mem[k][8'h80] = wd;
      ref_mem[k][8'h81] = wd;
      run_req(k, 1'b0, 8'h80, 4'd5, 16'h0000);
   endtask

   task automatic test_reset_drain(input int k);
      int nbad = 0;
      wait_ready(k);
      req_valid[k] = 1'b1;
      req_write = 1'b0; req_addr = 8'h40; req_len = 4'd3;
      @(negedge clk);
      req_valid[k] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy[k] !== 1'b1) begin
         errors++;
         $display("FAIL rst_drain_busy lat%0d: busy=%b required 1", k + 1, busy[k]);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (rd_valid[k] !== 1'b0 || done[k] !== 1'b0) nbad++;
         @(negedge clk);
      end
      checks++;
      if (nbad != 0) begin
         errors++;
         $display("FAIL rst_drain lat%0d: %0d cycles with rd_valid/done after reset, required 0", k + 1, nbad);
      end
   endtask

   task automatic test_random(input int k);
      for (int n = 0; n < 20; n++) begin
         run_req(k, 1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)), 16'($urandom));
      end
   endtask

   initial begin
      reset = 1'b1;
      preload = 1'b1;
      req_write = 1'b0;
      req_addr = 8'h00;
      req_len = 4'd0;
      req_wdata = 16'h0000;
      for (int k = 0; k < N; k++) req_valid[k] = 1'b0;
      test_reset();
      for (int k = 0; k < N; k++) begin
         test_single(k);
         test_fill_wrap(k);
         test_max_burst(k);
         test_busy(k);
         test_reset_mid(k);
         test_reset_drain(k);
         test_random(k);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
